ifid_stage_buf: RTL

Parametrised IF/ID pipeline stage buffer between instruction fetch and decode. It replaces the plain fetch/decode latch with a 2-entry skid buffer. The buffer uses a valid/ready handshake on both sides, so decode can stall without losing a fetched instruction. It also has a flush input for branch redirect and injects a NOP bubble whenever no valid instruction is held.

---
 rtl/ifid_stage_buf.sv | 102 ++++++++++
 1 files changed

// File: rtl/ifid_stage_buf.sv
// ============================================================================
// Module   : ifid_stage_buf
// Purpose  : IF/ID stage buffer. A 2-entry skid buffer with valid/ready on
//            both sides, flush for branch redirect, and NOP bubble injection.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ifid_stage_buf #(
  parameter int                   INSTR_W   = 32,
  parameter int                   ADDR_W    = 14,
  parameter logic [INSTR_W-1:0]   NOP_INSTR = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] instr_i,
  input  logic [ADDR_W-1:0]  addr_i,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] instr_o,
  output logic [ADDR_W-1:0]  addr_o,
  input  logic               flush,
  output logic [1:0]         level
);

  logic               r_main_v;
  logic [INSTR_W-1:0] r_main_instr;
  logic [ADDR_W-1:0]  r_main_addr;
  logic               r_skid_v;
  logic [INSTR_W-1:0] r_skid_instr;
  logic [ADDR_W-1:0]  r_skid_addr;
  logic               r_in_ready;

  logic w_accept;
  logic w_issue;

  assign w_accept = in_valid && r_in_ready;
  assign w_issue  = r_main_v && out_ready;

  // Valid bits and the registered ready; flush overrides every handshake rule.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_main_v   <= 1'b0;
      r_skid_v   <= 1'b0;
      r_in_ready <= 1'b1;
    end else if (flush) begin
      r_main_v   <= 1'b0;
      r_skid_v   <= 1'b0;
      r_in_ready <= 1'b1;
    end else if (r_skid_v) begin
      if (w_issue) begin
        r_skid_v   <= 1'b0;
        r_in_ready <= 1'b1;
      end
    end else if (w_accept) begin
      if (!r_main_v || w_issue) begin
        r_main_v <= 1'b1;
      end else begin
        r_skid_v   <= 1'b1;
        r_in_ready <= 1'b0;
      end
    end else if (w_issue) begin
      r_main_v <= 1'b0;
    end
  end

  // Data registers move only on accept or skid-to-main; they keep their value across flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_main_instr <= NOP_INSTR;
      r_main_addr  <= '0;
      r_skid_instr <= NOP_INSTR;
      r_skid_addr  <= '0;
    end else if (!flush) begin
      if (r_skid_v) begin
        if (w_issue) begin
          r_main_instr <= r_skid_instr;
          r_main_addr  <= r_skid_addr;
        end
      end else if (w_accept) begin
        if (!r_main_v || w_issue) begin
          r_main_instr <= instr_i;
          r_main_addr  <= addr_i;
        end else begin
          r_skid_instr <= instr_i;
          r_skid_addr  <= addr_i;
        end
      end
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_main_v;
  assign instr_o   = r_main_v ? r_main_instr : NOP_INSTR;
  assign addr_o    = r_main_addr;
  assign level     = {1'b0, r_main_v} + {1'b0, r_skid_v};

endmodule

`default_nettype wire
